unified_mem_port: RTL and testbench

- Unified instruction/data memory with a single physical port, shared by the fetch stage and the MEM stage. Replaces the half-clock time-multiplexing of one memory.
- Arbitrates per cycle between a fetch channel and a data channel using req/gnt handshakes.
- Returns registered read data one cycle after grant.
- Supports byte/half/word accesses with sign or zero extension, misalignment detection and a starvation guard for fetch.

---
 rtl/unified_mem_port.sv | 166 ++++++++++++++++
 tb/tb_unified_mem_port.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/unified_mem_port.sv
// unified_mem_port: single-port unified instruction/data memory shared by the
// fetch channel and the data channel. Per-cycle req/gnt arbitration favours
// data, with a starvation guard for fetch. Read data is registered one cycle
// after grant. Data accesses support byte/half/word with sign/zero extension
// and fault detection.
module unified_mem_port #(
    parameter int unsigned ADDR_WIDTH   = 10,
    parameter int unsigned DEPTH_WORDS  = 256,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [31:0]           if_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [1:0]            d_size,
    input  logic                  d_signed,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [31:0]           d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [31:0]           d_rdata,
    output logic                  d_err
);

    localparam int unsigned IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned CNT_W     = $clog2(STARVE_LIMIT + 1);
    localparam int unsigned MEM_BYTES = DEPTH_WORDS * 4;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_BAD  = 2'b11
    } size_e;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic             if_rvalid_q, if_rvalid_d;
    logic [31:0]      if_rdata_q,  if_rdata_d;
    logic             d_rvalid_q,  d_rvalid_d;
    logic [31:0]      d_rdata_q,   d_rdata_d;
    logic             d_err_q,     d_err_d;
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

    logic [IDX_W-1:0] if_idx;
    logic [IDX_W-1:0] d_idx;
    logic [1:0]       byte_off;
    logic [31:0]      rd_word;
    logic [7:0]       ld_byte;
    logic [15:0]      ld_half;
    logic [31:0]      load_ext;
    logic [31:0]      wr_word;
    logic             d_fault;
    logic             mem_we;

    // Word indices; the fetch index wraps modulo the memory depth, the data
    // index only matters when the access is in range (otherwise it faults).
    assign if_idx   = IDX_W'((32'(if_addr) >> 2) % DEPTH_WORDS);
    assign d_idx    = IDX_W'((32'(d_addr) >> 2) % DEPTH_WORDS);
    assign byte_off = d_addr[1:0];
    assign rd_word  = mem_q[d_idx];

    // Arbitration: data wins unless fetch has waited STARVE_LIMIT grants.
    assign d_gnt  = rst & d_req & (~if_req | (starve_cnt_q < LIMIT));
    assign if_gnt = rst & if_req & ~d_gnt;

    // Fault decode: illegal size, misalignment, or address beyond the array.
    always_comb begin
        d_fault = 1'b0;
        unique case (size_e'(d_size))
            SZ_BYTE: d_fault = 1'b0;
            SZ_HALF: d_fault = d_addr[0];
            SZ_WORD: d_fault = (byte_off != 2'b00);
            SZ_BAD:  d_fault = 1'b1;
        endcase
        if (32'(d_addr) >= MEM_BYTES) d_fault = 1'b1;
    end

    // Load lane extraction/extension and store lane merge into the old word.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
        ld_byte  = rd_word[{byte_off, 3'b000} +: 8];
        ld_half  = rd_word[{byte_off[1], 4'b0000} +: 16];
        load_ext = rd_word;
        wr_word  = rd_word;
        unique case (size_e'(d_size))
            SZ_BYTE: begin
                load_ext = {{24{ld_byte[7] & d_signed}}, ld_byte};
                wr_word[{byte_off, 3'b000} +: 8] = d_wdata[7:0];
            end
            SZ_HALF: begin
                load_ext = {{16{ld_half[15] & d_signed}}, ld_half};
                wr_word[{byte_off[1], 4'b0000} +: 16] = d_wdata[15:0];
            end
            SZ_WORD: begin
                load_ext = rd_word;
                wr_word  = d_wdata;
            end
            SZ_BAD: begin
                load_ext = 32'd0;
                wr_word  = rd_word;
            end
        endcase
    end

    assign mem_we = d_gnt & d_we & ~d_fault;

    // Next-state for response registers and the starvation counter.
    always_comb begin
        if_rvalid_d  = if_gnt;
        if_rdata_d   = if_gnt ? mem_q[if_idx] : if_rdata_q;
        d_rvalid_d   = d_gnt;
        d_err_d      = d_gnt & d_fault;
        d_rdata_d    = d_rdata_q;
        starve_cnt_d = starve_cnt_q;
        if (d_gnt && d_fault) begin
            d_rdata_d = 32'd0;
        end else if (d_gnt && !d_we) begin
            d_rdata_d = load_ext;
        end
        if (!if_req || if_gnt) begin
            starve_cnt_d = '0;
        end else if (d_gnt && (starve_cnt_q < LIMIT)) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    // Response and arbitration state; reset discards any in-flight result.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values together.
        if (!rst) begin
            if_rvalid_q  <= 1'b0;
            if_rdata_q   <= 32'd0;
            d_rvalid_q   <= 1'b0;
            d_rdata_q    <= 32'd0;
            d_err_q      <= 1'b0;
            starve_cnt_q <= '0;
        end else begin
            if_rvalid_q  <= if_rvalid_d;
            if_rdata_q   <= if_rdata_d;
            d_rvalid_q   <= d_rvalid_d;
            d_rdata_q    <= d_rdata_d;
            d_err_q      <= d_err_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset so it maps onto RAM; contents survive rst.
        if (mem_we) mem_q[d_idx] <= wr_word;
    end

    assign if_rvalid = if_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign d_rvalid  = d_rvalid_q;
    assign d_rdata   = d_rdata_q;
    assign d_err     = d_err_q;

endmodule

// File: tb/tb_unified_mem_port.sv
// Self-checking bench for unified_mem_port: table-driven data accesses plus
// hand-written sequences for fetch, ordering, starvation and reset.
module tb_unified_mem_port;

    localparam int AW = 11;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [31:0]   if_rdata;
    logic          d_req;
    logic          d_we;
    logic [1:0]    d_size;
    logic          d_signed;
    logic [AW-1:0] d_addr;
    logic [31:0]   d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [31:0]   d_rdata;
    logic          d_err;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string         name;
        logic          we;
        logic [1:0]    size;
        logic          sgn;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
        logic          chk_rd;
        logic [31:0]   exp_rdata;
        logic          exp_err;
    } vec_t;

    vec_t tbl[$];
    bit   pat [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

    always #5 clk = ~clk;

    unified_mem_port #(
        .ADDR_WIDTH  (AW),
        .DEPTH_WORDS (256),
        .STARVE_LIMIT(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_gnt   (if_gnt),
        .if_rvalid(if_rvalid),
        .if_rdata (if_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_size   (d_size),
        .d_signed (d_signed),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .d_err    (d_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string n, input logic we, input logic [1:0] sz,
                                input logic sg, input logic [AW-1:0] a, input logic [31:0] wd,
                                input logic chk, input logic [31:0] er, input logic ee);
        vec_t v;
        v.name = n; v.we = we; v.size = sz; v.sgn = sg; v.addr = a; v.wdata = wd;
        v.chk_rd = chk; v.exp_rdata = er; v.exp_err = ee;
        return v;
    endfunction

    // Waits (bounded) for the grant on the chosen channel; called at posedge+1.
    task automatic wait_gnt(input bit dch, input string name);
        int n = 0;
        #1;
        while (!(dch ? d_gnt : if_gnt) && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 20) begin
            checks++;
            failures++;
            $display("FAIL %s grant timeout: got 0 expected 1", name);
        end
    endtask

    task automatic data_op(input vec_t v);
        d_req = 1'b1; d_we = v.we; d_size = v.size; d_signed = v.sgn;
        d_addr = v.addr; d_wdata = v.wdata;
        wait_gnt(1'b1, v.name);
        @(posedge clk); #1;
        d_req = 1'b0; d_we = 1'b0;
        check({v.name, " rvalid"}, 32'(d_rvalid), 32'd1);
        check({v.name, " err"}, 32'(d_err), 32'(v.exp_err));
        if (v.chk_rd) check({v.name, " rdata"}, d_rdata, v.exp_rdata);
    endtask

    task automatic fetch_op(input logic [AW-1:0] a, input logic [31:0] exp, input string name);
        if_req = 1'b1; if_addr = a;
        wait_gnt(1'b0, name);
        @(posedge clk); #1;
        if_req = 1'b0;
        check({name, " rvalid"}, 32'(if_rvalid), 32'd1);
        check({name, " rdata"}, if_rdata, exp);
        check({name, " no d_rvalid"}, 32'(d_rvalid), 32'd0);
        @(posedge clk); #1;
        check({name, " rvalid pulse"}, 32'(if_rvalid), 32'd0);
        check({name, " rdata hold"}, if_rdata, exp);
    endtask

    initial begin
        rst = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_size = 2'b10; d_signed = 1'b0; d_addr = '0; d_wdata = '0;

        // Reset state, grants suppressed while in reset.
        #2 rst = 1'b0;
        #1;
        check("rst if_rvalid", 32'(if_rvalid), 32'd0);
        check("rst d_rvalid", 32'(d_rvalid), 32'd0);
        check("rst d_err", 32'(d_err), 32'd0);
        check("rst if_rdata", if_rdata, 32'd0);
        check("rst d_rdata", d_rdata, 32'd0);
        d_req = 1'b1; if_req = 1'b1;
        #1;
        check("rst d_gnt", 32'(d_gnt), 32'd0);
        check("rst if_gnt", 32'(if_gnt), 32'd0);
        d_req = 1'b0; if_req = 1'b0;
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;

        // Store a word, then fetch it through aligned, unaligned and wrapped addresses.
        data_op(mk("st_w10", 1, 2'b10, 0, 11'h010, 32'hDEADBEEF, 0, 0, 0));
        fetch_op(11'h010, 32'hDEADBEEF, "fetch_10");
        fetch_op(11'h013, 32'hDEADBEEF, "fetch_13");
        fetch_op(11'h410, 32'hDEADBEEF, "fetch_410_wrap");

        tbl.push_back(mk("st_w0",        1, 2'b10, 0, 11'h000, 32'h0BADF00D, 0, 32'h0,        0));
        tbl.push_back(mk("ld_b13_s",     0, 2'b00, 1, 11'h013, 32'h0,        1, 32'hFFFFFFDE, 0));
        tbl.push_back(mk("ld_b13_u",     0, 2'b00, 0, 11'h013, 32'h0,        1, 32'h000000DE, 0));
        tbl.push_back(mk("ld_h12_s",     0, 2'b01, 1, 11'h012, 32'h0,        1, 32'hFFFFDEAD, 0));
        tbl.push_back(mk("ld_h10_u",     0, 2'b01, 0, 11'h010, 32'h0,        1, 32'h0000BEEF, 0));
        tbl.push_back(mk("ld_h10_s",     0, 2'b01, 1, 11'h010, 32'h0,        1, 32'hFFFFBEEF, 0));
        tbl.push_back(mk("ld_w10_sgn",   0, 2'b10, 1, 11'h010, 32'h0,        1, 32'hDEADBEEF, 0));
        tbl.push_back(mk("st_b11",       1, 2'b00, 0, 11'h011, 32'hAAAAAA55, 0, 32'h0,        0));
        tbl.push_back(mk("ld_w10_a",     0, 2'b10, 0, 11'h010, 32'h0,        1, 32'hDEAD55EF, 0));
        tbl.push_back(mk("st_h12",       1, 2'b01, 0, 11'h012, 32'hFFFF1234, 0, 32'h0,        0));
        tbl.push_back(mk("ld_w10_b",     0, 2'b10, 0, 11'h010, 32'h0,        1, 32'h123455EF, 0));
        tbl.push_back(mk("flt_ld_w12",   0, 2'b10, 0, 11'h012, 32'h0,        1, 32'h0,        1));
        tbl.push_back(mk("flt_st_h11",   1, 2'b01, 0, 11'h011, 32'hFFFFFFFF, 1, 32'h0,        1));
        tbl.push_back(mk("flt_sz11",     0, 2'b11, 0, 11'h010, 32'h0,        1, 32'h0,        1));
        tbl.push_back(mk("flt_st_400",   1, 2'b10, 0, 11'h400, 32'hFFFFFFFF, 1, 32'h0,        1));
        tbl.push_back(mk("flt_ld_400",   0, 2'b10, 0, 11'h400, 32'h0,        1, 32'h0,        1));
        tbl.push_back(mk("ld_w10_post",  0, 2'b10, 0, 11'h010, 32'h0,        1, 32'h123455EF, 0));
        tbl.push_back(mk("ld_w0_post",   0, 2'b10, 0, 11'h000, 32'h0,        1, 32'h0BADF00D, 0));
        tbl.push_back(mk("ld_b10_s",     0, 2'b00, 1, 11'h010, 32'h0,        1, 32'hFFFFFFEF, 0));
        tbl.push_back(mk("ld_b11_u",     0, 2'b00, 0, 11'h011, 32'h0,        1, 32'h00000055, 0));
        tbl.push_back(mk("ld_h10_s2",    0, 2'b01, 1, 11'h010, 32'h0,        1, 32'h000055EF, 0));
        tbl.push_back(mk("st_b13_hold",  1, 2'b00, 0, 11'h013, 32'h00000012, 1, 32'h000055EF, 0));
        foreach (tbl[i]) data_op(tbl[i]);

        // Store on data and fetch of the same word requested together.
        d_req = 1'b1; d_we = 1'b1; d_size = 2'b10; d_addr = 11'h020; d_wdata = 32'hCAFEF00D;
        if_req = 1'b1; if_addr = 11'h020;
        #1;
        check("ord d_gnt", 32'(d_gnt), 32'd1);
        check("ord if_gnt wait", 32'(if_gnt), 32'd0);
        @(posedge clk); #1;
        d_req = 1'b0; d_we = 1'b0;
        check("ord d_rvalid", 32'(d_rvalid), 32'd1);
        #1;
        check("ord if_gnt", 32'(if_gnt), 32'd1);
        @(posedge clk); #1;
        if_req = 1'b0;
        check("ord if_rvalid", 32'(if_rvalid), 32'd1);
        check("ord if_rdata", if_rdata, 32'hCAFEF00D);
        check("ord d_rvalid off", 32'(d_rvalid), 32'd0);
        @(posedge clk); #1;

        // Both channels held high: grant pattern D,D,D,D,F repeating.
        d_req = 1'b1; d_we = 1'b0; d_size = 2'b10; d_signed = 1'b0; d_addr = 11'h010;
        if_req = 1'b1; if_addr = 11'h020;
        for (int i = 0; i < 10; i++) begin
            #1;
            check($sformatf("starve d_gnt %0d", i), 32'(d_gnt), 32'(pat[i]));
            check($sformatf("starve if_gnt %0d", i), 32'(if_gnt), 32'(!pat[i]));
            if (i > 0) begin
                check($sformatf("starve d_rvalid %0d", i), 32'(d_rvalid), 32'(pat[i-1]));
                check($sformatf("starve if_rvalid %0d", i), 32'(if_rvalid), 32'(!pat[i-1]));
            end
            @(posedge clk);
        end
        #1;
        d_req = 1'b0; if_req = 1'b0;
        check("starve last d_rvalid", 32'(d_rvalid), 32'd0);
        check("starve last if_rvalid", 32'(if_rvalid), 32'd1);
        check("starve if_rdata", if_rdata, 32'hCAFEF00D);
        check("starve d_rdata", d_rdata, 32'h123455EF);
        @(posedge clk); #1;

        // Reset asserted the cycle after a load grant discards the result.
        d_req = 1'b1; d_we = 1'b0; d_size = 2'b10; d_addr = 11'h000;
        #1;
        check("rst2 d_gnt", 32'(d_gnt), 32'd1);
        @(posedge clk); #1;
        d_req = 1'b0;
        rst = 1'b0;
        #1;
        check("rst2 d_rvalid", 32'(d_rvalid), 32'd0);
        check("rst2 d_rdata", d_rdata, 32'd0);
        d_req = 1'b1; if_req = 1'b1;
        #1;
        check("rst2 d_gnt low", 32'(d_gnt), 32'd0);
        check("rst2 if_gnt low", 32'(if_gnt), 32'd0);
        d_req = 1'b0; if_req = 1'b0;
        @(negedge clk) rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check($sformatf("post_rst d_rvalid %0d", i), 32'(d_rvalid), 32'd0);
            check($sformatf("post_rst if_rvalid %0d", i), 32'(if_rvalid), 32'd0);
        end
        data_op(mk("post_rst_st30", 1, 2'b10, 0, 11'h030, 32'h13579BDF, 0, 32'h0, 0));
        data_op(mk("post_rst_ld30", 0, 2'b10, 0, 11'h030, 32'h0, 1, 32'h13579BDF, 0));
        data_op(mk("post_rst_ld10", 0, 2'b10, 0, 11'h010, 32'h0, 1, 32'h123455EF, 0));
        fetch_op(11'h030, 32'h13579BDF, "post_rst_fetch30");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
